// File: rtl/seq_divider_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : seq_divider_pkg                                              |
// | Description : Shared constants and state encoding for the sequential       |
// |               restoring divider.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_divider_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Quotient reported for a zero divisor.
  localparam logic [WIDTH_DEFAULT-1:0] DBZ_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// +----------------------------------------------------------------------------+
// | Module      : div_step                                                     |
// | Description : One combinational restoring-division iteration.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // One extra bit so the borrow of the trial subtraction is visible.
  assign w_shifted = {rem, dvd_msb};
  assign w_diff    = w_shifted - {1'b0, divisor};
  assign q_bit     = ~w_diff[WIDTH];
  assign next_rem  = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------------+
// | Module      : seq_divider                                                  |
// | Description : Iterative signed/unsigned restoring divider (DIV/DIVU).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic             r_sa;
  logic             r_sb;
  logic             r_dbz_sel;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dbz;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_qbit;
  logic             w_busy;
  logic             w_in_fix;

  assign w_sa     = sign & a[WIDTH-1];
  assign w_sb     = sign & b[WIDTH-1];
  assign w_abs_a  = w_sa ? (~a + 1'b1) : a;
  assign w_abs_b  = w_sb ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);

  div_step #(
    .WIDTH    (WIDTH)
  ) u_div_step (
    .rem      (r_rem),
    .dvd_msb  (r_dvd[WIDTH-1]),
    .divisor  (r_div),
    .next_rem (w_step_rem),
    .q_bit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_b_zero ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_last_cnt) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_in_fix = (r_state == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_div       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_dbz_sel   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= w_in_fix;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa      <= w_sa;
            r_sb      <= w_sb;
            r_div     <= w_abs_b;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dbz_sel <= w_b_zero;
            // A zero divisor keeps the raw dividend so it can be returned as-is.
            r_dvd     <= w_b_zero ? a : w_abs_a;
          end
        end
        S_CALC: begin
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_dbz_sel) begin
            r_quotient  <= {WIDTH{DBZ_QUOTIENT[0]}};
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= (r_sa ^ r_sb) ? (~r_dvd + 1'b1) : r_dvd;
            r_remainder <= r_sa ? (~r_rem + 1'b1) : r_rem;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dbz       = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_divider                                               |
// | Description : Self-checking bench for seq_divider with a reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(
    .WIDTH     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Division defined on magnitudes with 64-bit arithmetic, then signs applied.
  function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint unsigned ma;
    longint unsigned mb;
    bit na;
    bit nb;
    if (rb == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = ra;
      dz = 1'b1;
      return;
    end
    na = rs && ra[31];
    nb = rs && rb[31];
    ma = na ? (64'h1_0000_0000 - {32'd0, ra}) : {32'd0, ra};
    mb = nb ? (64'h1_0000_0000 - {32'd0, rb}) : {32'd0, rb};
    q  = 32'(ma / mb);
    r  = 32'(ma % mb);
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    dz = 1'b0;
  endfunction

  // Start one operation at the current (post-edge) time and wait for done.
  // With chain set, the caller issues the next start in the done cycle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input bit chain);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed;
    int          n;
    int          busy_low;
    ref_div(ta, tb, ts, eq, er, ed);
    a = ta; b = tb; sign = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busy_low = 0;
    while (!done && n < 100) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, ed ? 32'd2 : 32'd34);
    check("busy_during", busy_low, 0);
    check("busy_at_done", {31'd0, busy}, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", {31'd0, dbz}, {31'd0, ed});
    if (!chain) begin
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 0);
      check("quotient_hold", quotient, eq);
      check("remainder_hold", remainder, er);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int dones;
    rst = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_dbz", {31'd0, dbz}, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 1'b0);
    run_op(32'd9, 32'd3, 1'b0, 1'b0);

    // Start while busy: a second start at edge 10 must be ignored.
    a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 9) begin
        a = 32'd50; b = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("busy_start_latency", n, 34);
    check("busy_start_quotient", quotient, 14);
    check("busy_start_remainder", remainder, 2);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_second_done", dones, 0);
    check("busy_start_hold_q", quotient, 14);
    check("busy_start_hold_r", remainder, 2);

    // Reset during the computation.
    a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op(32'd81, 32'd9, 1'b0, 1'b0);

    // Back-to-back: next start issued in the done cycle.
    run_op(32'd100, 32'd7, 1'b0, 1'b1);
    run_op(32'd10, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'd0 - $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
